// File: rtl/delay_sampler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : delay_sampler_pkg                                            |
// | Description : Shared types for the delay_sampler timing-control engine.    |
// |               mode_e  - per-request sampling mode                          |
// |               state_e - per-channel FSM state                              |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package delay_sampler_pkg;

  // Sampling mode carried with each request.
  typedef enum logic {
    DELAY_THEN_SAMPLE = 1'b0,  // wait D cycles, then sample din
    SAMPLE_THEN_DELAY = 1'b1   // sample din now, present it after D cycles
  } mode_e;

  // Per-channel FSM state.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage : delay_sampler_pkg
`default_nettype wire

// File: rtl/delay_sampler_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : delay_sampler_ch                                             |
// | Description : One independent delay/sample channel: two-state FSM, delay   |
// |               down-counter, hold register and registered outputs.          |
// | Ports       : clk      - clock, rising edge                                |
// |               rst_n    - asynchronous active-low reset                     |
// |               i_req    - request pulse                                     |
// |               i_delay  - delay D, sampled with i_req                       |
// |               i_mode   - mode, sampled with i_req (see mode_e)             |
// |               i_din    - data input                                        |
// |               o_dout   - result, holds until the next completion           |
// |               o_valid  - one-cycle completion pulse                        |
// |               o_busy   - request pending                                   |
// |               o_drop   - one-cycle pulse for a rejected request            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module delay_sampler_ch
  import delay_sampler_pkg::*;
#(
  parameter int W      = 8,
  parameter int CNT_W  = 8,
  parameter int RETRIG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [CNT_W-1:0] i_delay,
  input  logic             i_mode,
  input  logic [W-1:0]     i_din,
  output logic [W-1:0]     o_dout,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_drop
);

  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  mode_e            r_mode,  w_mode_nxt;
  logic [W-1:0]     r_hold,  w_hold_nxt;
  logic [W-1:0]     r_dout,  w_dout_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_drop,  w_drop_nxt;
  logic             w_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_mode  <= DELAY_THEN_SAMPLE;
      r_hold  <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mode  <= w_mode_nxt;
      r_hold  <= w_hold_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mode_nxt  = r_mode;
    w_hold_nxt  = r_hold;
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_drop_nxt  = 1'b0;
    w_load      = 1'b0;

    case (r_state)
      IDLE: begin
        if (i_req) begin
          w_load      = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          // Completion; a request on this same edge is accepted without a
          // bubble, the old result still comes from the old hold/mode.
          w_dout_nxt  = (r_mode == SAMPLE_THEN_DELAY) ? r_hold : i_din;
          w_valid_nxt = 1'b1;
          if (i_req) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (i_req && (RETRIG != 0)) begin
          // Restart: the aborted request never completes.
          w_load = 1'b1;
        end else begin
          w_drop_nxt = i_req;
          w_cnt_nxt  = r_cnt - C_CNT_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_load) begin
      w_cnt_nxt  = i_delay;
      w_mode_nxt = mode_e'(i_mode);
      if (i_mode) begin
        w_hold_nxt = i_din;
      end
    end
  end

  assign o_dout  = r_dout;
  assign o_valid = r_valid;
  assign o_busy  = (r_state == WAIT);
  assign o_drop  = r_drop;

endmodule : delay_sampler_ch
`default_nettype wire

// File: rtl/delay_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : delay_sampler                                                |
// | Description : Multi-channel cycle-accurate delay/sample engine. Each of    |
// |               CH channels runs delay-then-sample or sample-then-delay with |
// |               a per-request delay; channel i uses slice i of each vector.  |
// | Ports       : clk    - clock, rising edge                                  |
// |               rst_n  - asynchronous active-low reset                       |
// |               req    [CH]        - request pulses                          |
// |               delay  [CH*CNT_W]  - per-channel delay D                     |
// |               mode   [CH]        - per-channel mode (see mode_e)           |
// |               din    [CH*W]      - per-channel data input                  |
// |               dout   [CH*W]      - per-channel result                      |
// |               valid  [CH]        - completion pulses                       |
// |               busy   [CH]        - request pending                         |
// |               drop   [CH]        - rejected-request pulses                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module delay_sampler
  import delay_sampler_pkg::*;
#(
  parameter int W      = 8,
  parameter int CH     = 4,
  parameter int CNT_W  = 8,
  parameter int RETRIG = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       req,
  input  logic [CH*CNT_W-1:0] delay,
  input  logic [CH-1:0]       mode,
  input  logic [CH*W-1:0]     din,
  output logic [CH*W-1:0]     dout,
  output logic [CH-1:0]       valid,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       drop
);

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    delay_sampler_ch #(
      .W      (W),
      .CNT_W  (CNT_W),
      .RETRIG (RETRIG)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (req[gi]),
      .i_delay (delay[gi*CNT_W +: CNT_W]),
      .i_mode  (mode[gi]),
      .i_din   (din[gi*W +: W]),
      .o_dout  (dout[gi*W +: W]),
      .o_valid (valid[gi]),
      .o_busy  (busy[gi]),
      .o_drop  (drop[gi])
    );
  end

endmodule : delay_sampler
`default_nettype wire

// File: tb/tb_delay_sampler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_delay_sampler                                             |
// | Description : Self-checking bench for delay_sampler. Two instances share   |
// |               stimulus: u_dut_a (RETRIG=0) and u_dut_b (RETRIG=1). A       |
// |               deadline-based reference model tracks both.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_delay_sampler;
  localparam int W = 8, CH = 4, CNT_W = 8;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [CH-1:0]       req, mode;
  logic [CH*CNT_W-1:0] delay;
  logic [CH*W-1:0]     din;
  logic [CH*W-1:0]     dout_a, dout_b;
  logic [CH-1:0]       valid_a, busy_a, drop_a, valid_b, busy_b, drop_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a pending request is just a completion deadline.
  bit           m_busy  [2][CH];
  int           m_end   [2][CH];
  bit           m_mode  [2][CH];
  logic [W-1:0] m_hold  [2][CH];
  logic [W-1:0] m_dout  [2][CH];
  bit           m_valid [2][CH];
  bit           m_drop  [2][CH];

  delay_sampler #(.W(W), .CH(CH), .CNT_W(CNT_W), .RETRIG(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req), .delay(delay), .mode(mode), .din(din),
    .dout(dout_a), .valid(valid_a), .busy(busy_a), .drop(drop_a));

  delay_sampler #(.W(W), .CH(CH), .CNT_W(CNT_W), .RETRIG(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req), .delay(delay), .mode(mode), .din(din),
    .dout(dout_b), .valid(valid_b), .busy(busy_b), .drop(drop_b));

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < CH; i++) begin
        m_busy[r][i] = 0; m_end[r][i] = 0; m_mode[r][i] = 0; m_hold[r][i] = '0;
        m_dout[r][i] = '0; m_valid[r][i] = 0; m_drop[r][i] = 0;
      end
    end
  endtask

  task automatic model_edge();
    cyc++;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < CH; i++) begin
        m_valid[r][i] = 0;
        m_drop[r][i]  = 0;
        if (m_busy[r][i] && cyc == m_end[r][i]) begin
          m_dout[r][i]  = m_mode[r][i] ? m_hold[r][i] : din[i*W +: W];
          m_valid[r][i] = 1;
          m_busy[r][i]  = 0;
        end
        if (req[i]) begin
          if (!m_busy[r][i] || r == 1) begin
            m_busy[r][i] = 1;
            m_end[r][i]  = cyc + int'(delay[i*CNT_W +: CNT_W]) + 1;
            m_mode[r][i] = mode[i];
            m_hold[r][i] = din[i*W +: W];
          end else begin
            m_drop[r][i] = 1;
          end
        end
      end
    end
  endtask

  // Advance one clock edge and leave time 1 unit after it for sampling.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge(); else model_clear();
    #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; mode = '0; delay = '0; din = '0;
    model_clear();
    tick(); tick();
    total++; if (dout_a !== '0)  begin bad++; $display("FAIL reset_dout_a got=%h exp=0", dout_a); end
    total++; if (valid_a !== '0) begin bad++; $display("FAIL reset_valid_a got=%b exp=0", valid_a); end
    total++; if (busy_a !== '0)  begin bad++; $display("FAIL reset_busy_a got=%b exp=0", busy_a); end
    total++; if (drop_b !== '0)  begin bad++; $display("FAIL reset_drop_b got=%b exp=0", drop_b); end
    rst_n = 1'b1;
    idle(2);
  endtask

  // Request at edge t (k=0); din on ch0 switches to 0x55 after edge t+5.
  task automatic test_mode(input bit m, input logic [W-1:0] exp_dout);
    din[7:0] = 8'h00; delay[7:0] = 8'd10; mode[0] = m; req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    total++; if (busy_a[0] !== 1'b1) begin bad++; $display("FAIL mode%0d_busy_start got=%b exp=1", m, busy_a[0]); end
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 5) din[7:0] = 8'h55;
      total++; if (busy_a[0] !== (k <= 10)) begin bad++; $display("FAIL mode%0d_busy k=%0d got=%b exp=%b", m, k, busy_a[0], (k <= 10)); end
      total++; if (valid_a[0] !== (k == 11)) begin bad++; $display("FAIL mode%0d_valid k=%0d got=%b exp=%b", m, k, valid_a[0], (k == 11)); end
      if (k == 11) begin
        total++; if (dout_a[7:0] !== exp_dout) begin bad++; $display("FAIL mode%0d_dout got=%h exp=%h", m, dout_a[7:0], exp_dout); end
      end
    end
    total++; if (dout_a[7:0] !== exp_dout) begin bad++; $display("FAIL mode%0d_dout_hold got=%h exp=%h", m, dout_a[7:0], exp_dout); end
    idle(3);
  endtask

  task automatic test_zero_delay();
    din[15:8] = 8'hA3; din[23:16] = 8'hA3;
    delay[15:8] = 8'd0; delay[23:16] = 8'd0;
    mode[1] = 1'b0; mode[2] = 1'b1; req[1] = 1'b1; req[2] = 1'b1;
    tick();
    req = '0;
    tick();
    total++; if (valid_a[2:1] !== 2'b11) begin bad++; $display("FAIL d0_valid got=%b exp=11", valid_a[2:1]); end
    total++; if (dout_a[15:8] !== 8'hA3) begin bad++; $display("FAIL d0_dout_mode0 got=%h exp=a3", dout_a[15:8]); end
    total++; if (dout_a[23:16] !== 8'hA3) begin bad++; $display("FAIL d0_dout_mode1 got=%h exp=a3", dout_a[23:16]); end
    tick();
    total++; if (valid_a[2:1] !== 2'b00) begin bad++; $display("FAIL d0_valid_pulse got=%b exp=00", valid_a[2:1]); end
    idle(3);
  endtask

  // ch3: D=20 at edge t, second request sampled at edge t+5 is rejected.
  task automatic test_drop();
    delay[31:24] = 8'd20; mode[3] = 1'b0; req[3] = 1'b1;
    tick();
    req[3] = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (k == 4) begin req[3] = 1'b1; delay[31:24] = 8'd7; end
      if (k == 5) req[3] = 1'b0;
      total++; if (drop_a[3] !== (k == 5)) begin bad++; $display("FAIL drop_pulse k=%0d got=%b exp=%b", k, drop_a[3], (k == 5)); end
      total++; if (valid_a[3] !== (k == 21)) begin bad++; $display("FAIL drop_valid k=%0d got=%b exp=%b", k, valid_a[3], (k == 21)); end
    end
    idle(5);
  endtask

  // ch0: D=20 at edge t; D=2 request lands on the cnt==0 edge t+21.
  task automatic test_back_to_back();
    din[7:0] = 8'h11; delay[7:0] = 8'd20; mode[0] = 1'b0; req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k == 20) begin req[0] = 1'b1; delay[7:0] = 8'd2; end
      if (k == 21) begin req[0] = 1'b0; din[7:0] = 8'h22; end
      total++; if (valid_a[0] !== (k == 21 || k == 24)) begin bad++; $display("FAIL b2b_valid k=%0d got=%b exp=%b", k, valid_a[0], (k == 21 || k == 24)); end
      total++; if (busy_a[0] !== (k <= 23)) begin bad++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy_a[0], (k <= 23)); end
      total++; if (drop_a[0] !== 1'b0) begin bad++; $display("FAIL b2b_drop k=%0d got=%b exp=0", k, drop_a[0]); end
      if (k == 21) begin
        total++; if (dout_a[7:0] !== 8'h11) begin bad++; $display("FAIL b2b_dout1 got=%h exp=11", dout_a[7:0]); end
      end
      if (k == 24) begin
        total++; if (dout_a[7:0] !== 8'h22) begin bad++; $display("FAIL b2b_dout2 got=%h exp=22", dout_a[7:0]); end
      end
    end
    idle(3);
  endtask

  // ch1 on the RETRIG=1 instance: D=20 at t, D=3 at t+5 -> single valid at t+9.
  task automatic test_retrig();
    din[15:8] = 8'h33; delay[15:8] = 8'd20; mode[1] = 1'b1; req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (k == 4) begin req[1] = 1'b1; delay[15:8] = 8'd3; din[15:8] = 8'h44; end
      if (k == 5) req[1] = 1'b0;
      total++; if (valid_b[1] !== (k == 9)) begin bad++; $display("FAIL retrig_valid k=%0d got=%b exp=%b", k, valid_b[1], (k == 9)); end
      total++; if (drop_b[1] !== 1'b0) begin bad++; $display("FAIL retrig_drop k=%0d got=%b exp=0", k, drop_b[1]); end
      if (k == 9) begin
        total++; if (dout_b[15:8] !== 8'h44) begin bad++; $display("FAIL retrig_dout got=%h exp=44", dout_b[15:8]); end
      end
    end
    idle(3);
  endtask

  task automatic test_independence();
    int d [CH];
    d[0] = 3; d[1] = 7; d[2] = 12; d[3] = 1;
    for (int i = 0; i < CH; i++) begin
      delay[i*CNT_W +: CNT_W] = CNT_W'(d[i]);
      din[i*W +: W] = W'(8'h10 + i);
    end
    mode = 4'b1010; req = '1;
    tick();
    req = '0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      for (int i = 0; i < CH; i++) begin
        total++; if (valid_a[i] !== (k == d[i] + 1)) begin bad++; $display("FAIL indep_valid ch=%0d k=%0d got=%b exp=%b", i, k, valid_a[i], (k == d[i] + 1)); end
      end
    end
    idle(3);
  endtask

  task automatic test_reset_mid();
    delay = {8'd17, 8'd13, 8'd9, 8'd5}; mode = 4'b0110; din = 32'hC3C2C1C0; req = '1;
    tick();
    req = '0;
    tick(); tick(); tick();
    total++; if (busy_a !== 4'hF) begin bad++; $display("FAIL rstmid_busy_before got=%b exp=1111", busy_a); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy_a !== '0 || busy_b !== '0) begin bad++; $display("FAIL rstmid_busy got=%b/%b exp=0", busy_a, busy_b); end
    total++; if (dout_a !== '0 || dout_b !== '0) begin bad++; $display("FAIL rstmid_dout got=%h/%h exp=0", dout_a, dout_b); end
    total++; if (valid_a !== '0 || drop_a !== '0) begin bad++; $display("FAIL rstmid_valid_drop got=%b/%b exp=0", valid_a, drop_a); end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      tick();
      total++; if (valid_a !== '0 || valid_b !== '0) begin bad++; $display("FAIL rstmid_no_valid k=%0d got=%b/%b exp=0", k, valid_a, valid_b); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < CH; i++) begin
        req[i] = ($urandom_range(0, 3) == 0);
        delay[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
        mode[i] = 1'($urandom_range(0, 1));
        din[i*W +: W] = W'($urandom);
      end
      tick();
      for (int r = 0; r < 2; r++) begin
        for (int i = 0; i < CH; i++) begin
          logic [W-1:0] gd;
          logic gv, gb, gp;
          gd = (r == 0) ? dout_a[i*W +: W] : dout_b[i*W +: W];
          gv = (r == 0) ? valid_a[i] : valid_b[i];
          gb = (r == 0) ? busy_a[i] : busy_b[i];
          gp = (r == 0) ? drop_a[i] : drop_b[i];
          total++;
          if (gv !== m_valid[r][i] || gb !== m_busy[r][i] || gp !== m_drop[r][i] || gd !== m_dout[r][i]) begin
            bad++;
            $display("FAIL rand n=%0d dut=%0d ch=%0d got v/b/d/dout=%b%b%b/%h exp=%b%b%b/%h",
                     n, r, i, gv, gb, gp, gd, m_valid[r][i], m_busy[r][i], m_drop[r][i], m_dout[r][i]);
          end
        end
      end
    end
    idle(20);
  endtask

  initial begin
    test_reset();
    test_mode(1'b0, 8'h55);
    test_mode(1'b1, 8'h00);
    test_zero_delay();
    test_drop();
    test_back_to_back();
    test_retrig();
    test_independence();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_delay_sampler
`default_nettype wire
